poly_seq_ctrl: RTL and testbench

- Start/done sequencer for the polynomial accumulate datapath (x register, y register, sum register, coefficient mux, multiply-accumulate).
- Evaluates y = c[DEGREE]*x^DEGREE + ... + c[0] by Horner's method.
- Drives load, clear and select strobes cycle by cycle, with a coefficient index counter.
- Replaces fixed free-running sequencing with a request-driven FSM for a configurable degree.

---
 rtl/poly_seq_ctrl.sv | 153 +++++++++++++++
 tb/tb_poly_seq_ctrl.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/poly_seq_ctrl.sv
// poly_seq_ctrl: request-driven start/done sequencer for the Horner
// polynomial accumulate datapath. Evaluates
//   y = c[DEGREE]*x^DEGREE + ... + c[0]
// by issuing one LOAD, one INIT (sum <= c[DEGREE]), DEGREE ITER cycles
// (sum <= sum*x + c[idx]), one WRITE (y <= sum) and a one-cycle DONE pulse.
//
// Optional feature: define POLY_SEQ_ABORT_EN to add an abort input that
// returns the sequencer to IDLE from any busy state without a y_ld or done.
//
// Handshake: start is a level request sampled on each rising clk edge. It is
// acted on only in IDLE and DONE (DONE chains straight into LOAD); while busy
// is high it is ignored and not remembered.
//
// All outputs are Moore-decoded from the state register and the idx counter,
// so no input reaches an output combinationally. state_dbg exposes the state
// register for observation.

module poly_seq_ctrl #(
    parameter int DEGREE = 3,
    parameter int IDX_W  = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
`ifdef POLY_SEQ_ABORT_EN
    input  logic             abort,
`endif
    output logic             x_ld,
    output logic             y_ld,
    output logic             sum_ld,
    output logic             sum_clr,
    output logic             mac_sel,
    output logic [IDX_W-1:0] coef_sel,
    output logic             busy,
    output logic             done,
    output logic [2:0]       state_dbg
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_INIT  = 3'd2,
        S_ITER  = 3'd3,
        S_WRITE = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    localparam logic [IDX_W-1:0] DEG_IDX = IDX_W'(DEGREE);
    localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);

    state_t           state;
    state_t           state_next;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] idx_next;
    logic             abort_req;

`ifdef POLY_SEQ_ABORT_EN
    assign abort_req = abort;
`else
    assign abort_req = 1'b0;
`endif

    // State and coefficient index registers; reset aborts any evaluation at once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
            idx   <= '0;
        end else begin
            state <= state_next;
            idx   <= idx_next;
        end
    end

    // Next-state and index update; abort overrides every busy-state transition.
    always_comb begin
        state_next = state;
        idx_next   = idx;
        case (state)
            S_IDLE: begin
                if (start) state_next = S_LOAD;
            end
            S_LOAD: begin
                idx_next   = DEG_IDX;
                state_next = S_INIT;
            end
            S_INIT: begin
                idx_next   = DEG_IDX - IDX_ONE;
                state_next = S_ITER;
            end
            S_ITER: begin
                // idx only counts down while nonzero, so it can never wrap.
                if (idx != '0) idx_next = idx - IDX_ONE;
                else           state_next = S_WRITE;
            end
            S_WRITE: begin
                state_next = S_DONE;
            end
            S_DONE: begin
                state_next = start ? S_LOAD : S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
                idx_next   = '0;
            end
        endcase
        if (abort_req && (state inside {S_LOAD, S_INIT, S_ITER, S_WRITE})) begin
            state_next = S_IDLE;
            idx_next   = '0;
        end
    end

    // Moore output decode from state and idx only.
    always_comb begin
        x_ld     = 1'b0;
        y_ld     = 1'b0;
        sum_ld   = 1'b0;
        sum_clr  = 1'b0;
        mac_sel  = 1'b0;
        coef_sel = '0;
        busy     = 1'b0;
        done     = 1'b0;
        case (state)
            S_LOAD: begin
                busy    = 1'b1;
                x_ld    = 1'b1;
                sum_clr = 1'b1;
            end
            S_INIT: begin
                busy     = 1'b1;
                sum_ld   = 1'b1;
                coef_sel = DEG_IDX;
            end
            S_ITER: begin
                busy     = 1'b1;
                sum_ld   = 1'b1;
                mac_sel  = 1'b1;
                coef_sel = idx;
            end
            S_WRITE: begin
                busy = 1'b1;
                y_ld = 1'b1;
            end
            S_DONE: begin
                done = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign state_dbg = state;

endmodule

// File: tb/tb_poly_seq_ctrl.sv
// tb_poly_seq_ctrl: directed-vector bench for poly_seq_ctrl (DEGREE=3).
// Each driver step sets the inputs for one cycle and pushes the hand-computed
// output vector expected after the next rising edge; a monitor pops and
// compares. Build with +define+POLY_SEQ_ABORT_EN to also exercise abort.
// Packed output order: {busy, done, y_ld, x_ld, sum_ld, sum_clr, mac_sel, coef_sel[1:0]}

module tb_poly_seq_ctrl;

    localparam int DEGREE = 3;
    localparam int IDX_W  = 2;
    localparam int W      = 9;

    localparam logic [W-1:0] E_IDLE  = 9'b0_0_0_0_0_0_0_00;
    localparam logic [W-1:0] E_LOAD  = 9'b1_0_0_1_0_1_0_00;
    localparam logic [W-1:0] E_INIT  = 9'b1_0_0_0_1_0_0_11;
    localparam logic [W-1:0] E_ITER2 = 9'b1_0_0_0_1_0_1_10;
    localparam logic [W-1:0] E_ITER1 = 9'b1_0_0_0_1_0_1_01;
    localparam logic [W-1:0] E_ITER0 = 9'b1_0_0_0_1_0_1_00;
    localparam logic [W-1:0] E_WRITE = 9'b1_0_1_0_0_0_0_00;
    localparam logic [W-1:0] E_DONE  = 9'b0_1_0_0_0_0_0_00;

    logic             clk;
    logic             reset;
    logic             start;
    logic             abort;
    logic             x_ld;
    logic             y_ld;
    logic             sum_ld;
    logic             sum_clr;
    logic             mac_sel;
    logic [IDX_W-1:0] coef_sel;
    logic             busy;
    logic             done;
    logic [2:0]       state_dbg;

    logic [W-1:0] exp_q[$];
    int           tag_q[$];
    int           vec_n    = 0;
    int           checks   = 0;
    int           failures = 0;
    event         async_ev;

    poly_seq_ctrl #(
        .DEGREE (DEGREE),
        .IDX_W  (IDX_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
`ifdef POLY_SEQ_ABORT_EN
        .abort     (abort),
`endif
        .x_ld      (x_ld),
        .y_ld      (y_ld),
        .sum_ld    (sum_ld),
        .sum_clr   (sum_clr),
        .mac_sel   (mac_sel),
        .coef_sel  (coef_sel),
        .busy      (busy),
        .done      (done),
        .state_dbg (state_dbg)
    );

    // Clock and initial reset.
    initial begin
        clk   = 1'b0;
        reset = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        forever #5 clk = ~clk;
    end

    // Scoreboard compare of one expected vector against the live outputs.
    task automatic do_check();
        logic [W-1:0] e;
        logic [W-1:0] a;
        int           t;
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        a = {busy, done, y_ld, x_ld, sum_ld, sum_clr, mac_sel, coef_sel};
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL vec%0d outputs got=%b exp=%b (state_dbg=%0d)", t, a, e, state_dbg);
        end
    endtask

    // Monitor: sample 2 time units after each rising edge.
    always @(posedge clk) begin
        #2;
        if (exp_q.size() > 0) do_check();
    end

    // Monitor for the asynchronous-reset check between clock edges.
    always @(async_ev) begin
        #1;
        if (exp_q.size() > 0) do_check();
    end

    // Driver: set inputs for the coming edge and push the expected result.
    task automatic cyc(input logic r, input logic s, input logic a, input logic [W-1:0] e);
        @(negedge clk);
        reset = r;
        start = s;
        abort = a;
        exp_q.push_back(e);
        tag_q.push_back(vec_n);
        vec_n++;
    endtask

    // One full evaluation from a sampled start; chain keeps start high throughout.
    task automatic eval(input logic chain);
        cyc(1'b1, 1'b1,  1'b0, E_LOAD);
        cyc(1'b1, chain, 1'b0, E_INIT);
        cyc(1'b1, chain, 1'b0, E_ITER2);
        cyc(1'b1, chain, 1'b0, E_ITER1);
        cyc(1'b1, chain, 1'b0, E_ITER0);
        cyc(1'b1, chain, 1'b0, E_WRITE);
        cyc(1'b1, chain, 1'b0, E_DONE);
    endtask

    initial begin
        // Reset held with start high: all outputs quiet, LOAD right after release.
        cyc(1'b0, 1'b1, 1'b0, E_IDLE);
        cyc(1'b0, 1'b1, 1'b0, E_IDLE);
        cyc(1'b0, 1'b1, 1'b0, E_IDLE);
        eval(1'b0);
        cyc(1'b1, 1'b0, 1'b0, E_IDLE);
        cyc(1'b1, 1'b0, 1'b0, E_IDLE);

        // Single evaluation timeline.
        eval(1'b0);
        cyc(1'b1, 1'b0, 1'b0, E_IDLE);

        // Continuous start: DONE chains straight into LOAD.
        eval(1'b1);
        eval(1'b1);
        cyc(1'b1, 1'b0, 1'b0, E_IDLE);

        // start pulses during cycles 2 and 4 are ignored.
        cyc(1'b1, 1'b1, 1'b0, E_LOAD);
        cyc(1'b1, 1'b0, 1'b0, E_INIT);
        cyc(1'b1, 1'b1, 1'b0, E_ITER2);
        cyc(1'b1, 1'b0, 1'b0, E_ITER1);
        cyc(1'b1, 1'b1, 1'b0, E_ITER0);
        cyc(1'b1, 1'b0, 1'b0, E_WRITE);
        cyc(1'b1, 1'b0, 1'b0, E_DONE);
        cyc(1'b1, 1'b0, 1'b0, E_IDLE);
        cyc(1'b1, 1'b0, 1'b0, E_IDLE);

        // Asynchronous reset in the middle of cycle 4 (ITER, coef_sel=1).
        cyc(1'b1, 1'b1, 1'b0, E_LOAD);
        cyc(1'b1, 1'b0, 1'b0, E_INIT);
        cyc(1'b1, 1'b0, 1'b0, E_ITER2);
        cyc(1'b1, 1'b0, 1'b0, E_ITER1);
        @(posedge clk);
        #3;
        reset = 1'b0;
        exp_q.push_back(E_IDLE);
        tag_q.push_back(vec_n);
        vec_n++;
        -> async_ev;
        cyc(1'b0, 1'b0, 1'b0, E_IDLE);
        cyc(1'b0, 1'b0, 1'b0, E_IDLE);
        cyc(1'b1, 1'b0, 1'b0, E_IDLE);
        cyc(1'b1, 1'b0, 1'b0, E_IDLE);
        eval(1'b0);
        cyc(1'b1, 1'b0, 1'b0, E_IDLE);

`ifdef POLY_SEQ_ABORT_EN
        // abort during cycle 4 returns to IDLE with no y_ld or done.
        cyc(1'b1, 1'b1, 1'b0, E_LOAD);
        cyc(1'b1, 1'b0, 1'b0, E_INIT);
        cyc(1'b1, 1'b0, 1'b0, E_ITER2);
        cyc(1'b1, 1'b0, 1'b0, E_ITER1);
        cyc(1'b1, 1'b0, 1'b1, E_IDLE);
        cyc(1'b1, 1'b0, 1'b0, E_IDLE);
        cyc(1'b1, 1'b0, 1'b0, E_IDLE);
        // abort in IDLE is ignored; start still launches an evaluation.
        cyc(1'b1, 1'b1, 1'b1, E_LOAD);
        cyc(1'b1, 1'b0, 1'b0, E_INIT);
        cyc(1'b1, 1'b0, 1'b0, E_ITER2);
        cyc(1'b1, 1'b0, 1'b0, E_ITER1);
        cyc(1'b1, 1'b0, 1'b0, E_ITER0);
        cyc(1'b1, 1'b0, 1'b0, E_WRITE);
        cyc(1'b1, 1'b0, 1'b0, E_DONE);
        // abort in DONE is ignored and start still chains.
        cyc(1'b1, 1'b1, 1'b1, E_LOAD);
        cyc(1'b1, 1'b0, 1'b0, E_INIT);
        cyc(1'b1, 1'b0, 1'b0, E_ITER2);
        cyc(1'b1, 1'b0, 1'b0, E_ITER1);
        cyc(1'b1, 1'b0, 1'b0, E_ITER0);
        cyc(1'b1, 1'b0, 1'b0, E_WRITE);
        cyc(1'b1, 1'b0, 1'b0, E_DONE);
        cyc(1'b1, 1'b0, 1'b0, E_IDLE);
`endif

        // Drain the scoreboard within a bounded number of cycles.
        for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(posedge clk);
        #4;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain pending=%0d required=0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global time limit.
    initial begin
        #200000;
        $display("FAIL timeout reached with %0d vectors pending", exp_q.size());
        $fatal(1, "time limit");
    end

endmodule
